// File: rtl/warp_issue_scheduler.sv
// warp_issue_scheduler: round-robin warp issue arbiter feeding a registered valid/ready issue slot
// ports: clk/rst (async active-low); per-warp valid_IB/branch_IB/active/dependent status in;
// clear_valid/clear_warpID from ALU resolve branches; issue_ready from Operand Collector;
// issue_valid/issue_warpID slot out; grant_Sched_IB one-hot pop strobe; br_pending_Sched status.
module warp_issue_scheduler #(
  parameter int NUM_WARPS = 8,
  parameter int LOGNUM_WARPS = $clog2(NUM_WARPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WARPS-1:0]    valid_IB_Sched,
  input  logic [NUM_WARPS-1:0]    branch_IB_Sched,
  input  logic [NUM_WARPS-1:0]    active_Sched,
  input  logic [NUM_WARPS-1:0]    dependent_Scb_Sched,
  input  logic                    clear_valid_ALU_Sched,
  input  logic [LOGNUM_WARPS-1:0] clear_warpID_ALU_Sched,
  input  logic                    issue_ready_OC_Sched,
  output logic                    issue_valid_Sched_OC,
  output logic [LOGNUM_WARPS-1:0] issue_warpID_Sched_OC,
  output logic [NUM_WARPS-1:0]    grant_Sched_IB,
  output logic [NUM_WARPS-1:0]    br_pending_Sched
);
  logic [LOGNUM_WARPS-1:0] rr_ptr, sel, cand;
  logic [NUM_WARPS-1:0] eligible, br_pending_n;
  logic found, slot_free, load;
  assign eligible = valid_IB_Sched & active_Sched & ~dependent_Scb_Sched & ~br_pending_Sched;
  assign slot_free = ~issue_valid_Sched_OC | issue_ready_OC_Sched;
  // rst gates load so no pop strobe escapes while the IBuffer is being reset
  assign load = rst & slot_free & found;
  assign grant_Sched_IB = load ? NUM_WARPS'(1) << sel : '0;
  // search starts just past the last winner; rr_ptr itself is checked last
  always_comb begin
    sel = '0;
    cand = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_WARPS; k++) begin
      cand = LOGNUM_WARPS'((int'(rr_ptr) + k) % NUM_WARPS);
      if (!found && eligible[cand]) begin
        sel = cand;
        found = 1'b1;
      end
    end
  end
  // clear applied before set so a same-cycle set on the same warp wins
  always_comb begin
    br_pending_n = br_pending_Sched;
    if (clear_valid_ALU_Sched) br_pending_n[clear_warpID_ALU_Sched] = 1'b0;
    if (load && branch_IB_Sched[sel]) br_pending_n[sel] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_valid_Sched_OC <= 1'b0;
      issue_warpID_Sched_OC <= '0;
      br_pending_Sched <= '0;
      rr_ptr <= LOGNUM_WARPS'(NUM_WARPS - 1);
    end else begin
      br_pending_Sched <= br_pending_n;
      if (load) begin
        issue_valid_Sched_OC <= 1'b1;
        issue_warpID_Sched_OC <= sel;
        rr_ptr <= sel;
      end else if (slot_free) begin
        issue_valid_Sched_OC <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_warp_issue_scheduler.sv
// tb_warp_issue_scheduler: directed scenarios plus randomized traffic against a behavioural model
module tb_warp_issue_scheduler;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [7:0] valid_ib = '0, branch_ib = '0, active = '0, dep = '0;
  logic clr_v = 1'b0;
  logic [2:0] clr_id = '0;
  logic ready = 1'b0;
  logic iv;
  logic [2:0] iid;
  logic [7:0] grant, bp;
  int total = 0, bad = 0;
  bit m_valid;
  int m_id, m_ptr;
  logic [7:0] m_bp, exp_grant, obs_grant;
  warp_issue_scheduler dut (
    .clk(clk), .rst(rst),
    .valid_IB_Sched(valid_ib), .branch_IB_Sched(branch_ib),
    .active_Sched(active), .dependent_Scb_Sched(dep),
    .clear_valid_ALU_Sched(clr_v), .clear_warpID_ALU_Sched(clr_id),
    .issue_ready_OC_Sched(ready),
    .issue_valid_Sched_OC(iv), .issue_warpID_Sched_OC(iid),
    .grant_Sched_IB(grant), .br_pending_Sched(bp)
  );
  always #5 clk = ~clk;
  task automatic model_reset();
    m_valid = 0; m_id = 0; m_ptr = N - 1; m_bp = '0;
  endtask
  // one clock: sample grant before the edge, advance the model at the edge, return 1 unit after it
  task automatic tick();
    int p;
    #1;
    p = -1;
    if (rst && (!m_valid || ready))
      for (int k = 1; k <= N; k++) begin
        int w;
        w = (m_ptr + k) % N;
        if (p < 0 && valid_ib[w] && active[w] && !dep[w] && !m_bp[w]) p = w;
      end
    exp_grant = (p >= 0) ? 8'h1 << p : 8'h0;
    obs_grant = grant;
    @(posedge clk);
    if (clr_v) m_bp[clr_id] = 1'b0;
    if (p >= 0) begin
      m_valid = 1; m_id = p; m_ptr = p;
      if (branch_ib[p]) m_bp[p] = 1'b1;
    end else if (!m_valid || ready) m_valid = 0;
    #1;
  endtask
  task automatic test_reset();
    valid_ib = 8'hFF; active = 8'hFF; ready = 1'b1;
    #3;
    total++; if (iv !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", iv); end
    total++; if (iid !== 3'd0) begin bad++; $display("FAIL reset_id: got %0d want 0", iid); end
    total++; if (bp !== 8'h00) begin bad++; $display("FAIL reset_bp: got %h want 00", bp); end
    total++; if (grant !== 8'h00) begin bad++; $display("FAIL reset_grant: got %h want 00", grant); end
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_round_robin();
    logic [7:0] e;
    for (int i = 0; i < 9; i++) begin
      tick();
      e = 8'h1 << (i % 8);
      total++; if (obs_grant !== e) begin bad++; $display("FAIL rr_grant[%0d]: got %h want %h", i, obs_grant, e); end
      total++; if (iv !== 1'b1 || iid !== 3'(i % 8)) begin bad++; $display("FAIL rr_issue[%0d]: got v=%b id=%0d want v=1 id=%0d", i, iv, iid, i % 8); end
    end
  endtask
  task automatic test_dependent();
    valid_ib = 8'b0010_0100; dep = 8'b0000_0100;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (obs_grant !== 8'h20 || iid !== 3'd5) begin bad++; $display("FAIL dep_only5[%0d]: got g=%h id=%0d want g=20 id=5", i, obs_grant, iid); end
    end
    dep = 8'h00;
    tick();
    total++; if (obs_grant !== 8'h04 || iv !== 1'b1 || iid !== 3'd2) begin bad++; $display("FAIL dep_wrap2: got g=%h v=%b id=%0d want g=04 v=1 id=2", obs_grant, iv, iid); end
  endtask
  task automatic test_stall();
    valid_ib = 8'h00;
    tick();
    total++; if (iv !== 1'b0) begin bad++; $display("FAIL stall_drain: got %b want 0", iv); end
    valid_ib = 8'h08; ready = 1'b0;
    tick();
    total++; if (obs_grant !== 8'h08 || iv !== 1'b1 || iid !== 3'd3) begin bad++; $display("FAIL stall_load: got g=%h v=%b id=%0d want g=08 v=1 id=3", obs_grant, iv, iid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (obs_grant !== 8'h00 || iv !== 1'b1 || iid !== 3'd3) begin bad++; $display("FAIL stall_hold[%0d]: got g=%h v=%b id=%0d want g=00 v=1 id=3", i, obs_grant, iv, iid); end
    end
    valid_ib = 8'h00; ready = 1'b1;
    tick();
    total++; if (obs_grant !== 8'h00 || iv !== 1'b0) begin bad++; $display("FAIL stall_accept: got g=%h v=%b want g=00 v=0", obs_grant, iv); end
  endtask
  task automatic test_branch();
    valid_ib = 8'h02; branch_ib = 8'h02;
    tick();
    total++; if (obs_grant !== 8'h02 || iid !== 3'd1 || bp !== 8'h02) begin bad++; $display("FAIL br_issue: got g=%h id=%0d bp=%h want g=02 id=1 bp=02", obs_grant, iid, bp); end
    branch_ib = 8'h00;
    tick();
    total++; if (obs_grant !== 8'h00 || iv !== 1'b0 || bp !== 8'h02) begin bad++; $display("FAIL br_skip: got g=%h v=%b bp=%h want g=00 v=0 bp=02", obs_grant, iv, bp); end
    clr_v = 1'b1; clr_id = 3'd1;
    tick();
    total++; if (obs_grant !== 8'h00 || bp !== 8'h00) begin bad++; $display("FAIL br_clear: got g=%h bp=%h want g=00 bp=00", obs_grant, bp); end
    clr_v = 1'b0;
    tick();
    total++; if (obs_grant !== 8'h02 || iv !== 1'b1 || iid !== 3'd1) begin bad++; $display("FAIL br_reissue: got g=%h v=%b id=%0d want g=02 v=1 id=1", obs_grant, iv, iid); end
  endtask
  task automatic test_set_clear();
    valid_ib = 8'h10; branch_ib = 8'h10; clr_v = 1'b1; clr_id = 3'd4;
    tick();
    total++; if (obs_grant !== 8'h10 || bp !== 8'h10) begin bad++; $display("FAIL sc_setwins: got g=%h bp=%h want g=10 bp=10", obs_grant, bp); end
    valid_ib = 8'h00; branch_ib = 8'h00; clr_id = 3'd6;
    tick();
    total++; if (bp !== 8'h10) begin bad++; $display("FAIL sc_nonpending: got bp=%h want 10", bp); end
    clr_id = 3'd4;
    tick();
    total++; if (bp !== 8'h00) begin bad++; $display("FAIL sc_clear4: got bp=%h want 00", bp); end
    clr_v = 1'b0;
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_ib = 8'($urandom);
      active = 8'($urandom | $urandom);
      dep = 8'($urandom & $urandom);
      branch_ib = 8'($urandom & $urandom & $urandom);
      clr_v = 1'($urandom_range(0, 1));
      clr_id = 3'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      tick();
      total++; if (obs_grant !== exp_grant) begin bad++; $display("FAIL rnd_grant[%0d]: got %h want %h", i, obs_grant, exp_grant); end
      total++; if (iv !== m_valid) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, iv, m_valid); end
      if (m_valid) begin
        total++; if (iid !== 3'(m_id)) begin bad++; $display("FAIL rnd_id[%0d]: got %0d want %0d", i, iid, m_id); end
      end
      total++; if (bp !== m_bp) begin bad++; $display("FAIL rnd_bp[%0d]: got %h want %h", i, bp, m_bp); end
    end
  endtask
  task automatic test_midreset();
    valid_ib = 8'hFF; active = 8'hFF; dep = 8'h00; branch_ib = 8'hFF; clr_v = 1'b0; ready = 1'b0;
    tick();
    total++; if (iv !== 1'b1 || bp === 8'h00) begin bad++; $display("FAIL mr_setup: got v=%b bp=%h want v=1 bp!=00", iv, bp); end
    rst = 1'b0;
    #1;
    total++; if (iv !== 1'b0 || grant !== 8'h00 || bp !== 8'h00) begin bad++; $display("FAIL mr_async: got v=%b g=%h bp=%h want v=0 g=00 bp=00", iv, grant, bp); end
    model_reset();
    #2;
    rst = 1'b1; branch_ib = 8'h00; ready = 1'b1;
    tick();
    total++; if (obs_grant !== 8'h01 || iv !== 1'b1 || iid !== 3'd0) begin bad++; $display("FAIL mr_first: got g=%h v=%b id=%0d want g=01 v=1 id=0", obs_grant, iv, iid); end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_dependent();
    test_stall();
    test_branch();
    test_set_clear();
    test_random();
    test_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/warp_issue_scheduler.md
Name: warp_issue_scheduler

Overview:
- Round-robin issue arbiter that selects one warp per cycle from the IBuffer heads.
- It considers only warps whose head instruction is valid, active, and free of scoreboard dependences, and which have no unresolved branch.
- The selected warp is registered into a valid/ready output stage toward the Operand Collector, and the IBuffer gets a one-hot pop grant.
- It sits between the per-warp IBuffer/scoreboard status vectors and the single shared issue port.

Parameters:
- NUM_WARPS, 8, number of warps arbitrated.
- LOGNUM_WARPS, $clog2(NUM_WARPS), warp ID width.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- valid_IB_Sched  input  NUM_WARPS  IBuffer head instruction present per warp.
- branch_IB_Sched  input  NUM_WARPS  head instruction is a branch, per warp.
- active_Sched  input  NUM_WARPS  warp enabled (launched, not exited).
- dependent_Scb_Sched  input  NUM_WARPS  scoreboard RAW/WAW hazard on the head instruction.
- clear_valid_ALU_Sched  input  1  branch resolved.
- clear_warpID_ALU_Sched  input  LOGNUM_WARPS  warp whose branch resolved.
- issue_ready_OC_Sched  input  1  Operand Collector accepts issue this cycle.
- issue_valid_Sched_OC  output  1  issue slot holds an instruction.
- issue_warpID_Sched_OC  output  LOGNUM_WARPS  warp in the issue slot.
- grant_Sched_IB  output  NUM_WARPS  one-hot pop strobe to IBuffer (combinational, same cycle as slot load).
- br_pending_Sched  output  NUM_WARPS  per-warp unresolved-branch status.

Behaviour:
- Reset (rst=0, async): issue_valid=0, issue_warpID=0, br_pending=0, rr_ptr=NUM_WARPS-1 (so warp 0 has first priority). grant_Sched_IB=0 while in reset.
- eligible[i] = valid_IB[i] & active[i] & ~dependent[i] & ~br_pending[i].
- slot_free = ~issue_valid | issue_ready_OC.
- load = slot_free & |eligible.
- Selection:
  - First eligible warp searching upward from rr_ptr+1, wrapping modulo NUM_WARPS.
  - The warp at rr_ptr itself has lowest priority and is still selectable.
- On load at the edge:
  - issue_valid <= 1, issue_warpID <= sel, rr_ptr <= sel.
  - grant_Sched_IB = onehot(sel) during that cycle, else 0.
- If slot_free and no eligible warp: issue_valid <= 0 at the edge. issue_warpID holds its last value (don't-care).
- If issue_valid & ~issue_ready_OC: slot holds. issue_warpID is stable, no grant, rr_ptr unchanged (valid/ready stability rule).
- Back-to-back issue: accept and new load happen in the same cycle, giving one issue per cycle sustained. The same warp may issue consecutively if it is the only eligible warp.
- Branch tracking:
  - On load with branch_IB[sel]=1, set br_pending[sel] at that edge.
  - On clear_valid_ALU, clear br_pending[clear_warpID] at the edge.
  - If set and clear target the same warp in the same cycle, set wins.
  - Clear of a non-pending warp is ignored.
- A warp whose active drops while br_pending=1 keeps br_pending until cleared. The scheduler does not flush.
- Inputs are sampled combinationally in the load cycle. The IBuffer and scoreboard must present the next head's valid/dependent by the following cycle.
- Reset mid-operation drops any held issue slot without a grant. The IBuffer must be reset concurrently.

Test Plan:
1. Reset release with valid_IB=8'hFF, all active, no dependences, ready=1 → warpIDs issue 0,1,2,...,7,0 on consecutive cycles; grant one-hot matches each issued warpID.
2. valid_IB=8'b0010_0100, dependent=8'b0000_0100, ready=1 → only warp 5 issues. When dependent[2] drops, next issue is warp 2 (search from 6 wraps to 2).
3. Warp 3 sole eligible, ready held 0 for 4 cycles → issue_valid=1 and warpID=3 stable for all 4 cycles, grant pulses only in the load cycle. Ready=1 then yields one accept and no duplicate grant.
4. Warp 1 head is a branch and issues → br_pending=8'h02 and warp 1 is skipped despite valid. clear_valid_ALU with warpID=1 → br_pending=0 next cycle and warp 1 is issuable again.
5. Same-cycle branch issue on warp 4 and clear_valid_ALU for warp 4 → br_pending[4]=1 afterward. Clear for a non-pending warp 6 → no change.
6. rst driven low mid-stream with issue_valid=1 → immediately issue_valid=0, grant=0, br_pending=0. After release, first issue is warp 0.
